// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles every non-clock/reset signal of the fetch stage.
//   master : seen from the fetch unit (drives Imem_Req/Imem_Addr, Instr, PC, ...)
//   slave  : seen from control + instruction memory (drives PC_Sel, PC_LdEn,
//            PC_Immed, Stall, Imem_Ack, Imem_Data)
interface fetch_unit_if;
  logic        PC_Sel;
  logic        PC_LdEn;
  logic [31:0] PC_Immed;
  logic        Stall;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic [31:0] PC;
  logic [31:0] Instr_Count;
  logic        Fetch_Err;

  modport master (
    input  PC_Sel, PC_LdEn, PC_Immed, Stall, Imem_Ack, Imem_Data,
    output Imem_Req, Imem_Addr, Instr, Instr_Valid, PC, Instr_Count, Fetch_Err
  );

  modport slave (
    output PC_Sel, PC_LdEn, PC_Immed, Stall, Imem_Ack, Imem_Data,
    input  Imem_Req, Imem_Addr, Instr, Instr_Valid, PC, Instr_Count, Fetch_Err
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage: owns the PC, requests words from a variable-latency
//   instruction memory, holds the fetched word for control and advances the PC
//   when control retires the instruction.
// Ports
//   Clk    : clock, rising edge
//   Reset  : synchronous, active-low reset
//   bus    : fetch_unit_if.master (control inputs, imem handshake, Instr/PC/status outputs)
//
// state | meaning
// IDLE  | one idle cycle after reset, no request
// FETCH | Imem_Req high at Imem_Addr=PC, waiting for Imem_Ack (bounded by TIMEOUT)
// EXEC  | Instr valid, waiting for control to retire it (Stall / PC_LdEn)
// HALT  | fetch timed out, everything frozen until reset
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  fetch_unit_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]     PC_INIT  = {PC_RESET[31:2], 2'b00};

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic          r_valid;
  logic [31:0]   r_count;
  logic          r_err;
  logic [CW-1:0] r_wait;

  logic [31:0]   w_offset;
  logic [31:0]   w_next_pc;

  // Shifting the whole immediate keeps the word-offset arithmetic modulo 2^32;
  // the top two immediate bits fall off the end.
  assign w_offset  = bus.PC_Sel ? (bus.PC_Immed << 2) : 32'd0;
  assign w_next_pc = r_pc + 32'd4 + w_offset;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_pc    <= PC_INIT;
      r_instr <= 32'd0;
      r_valid <= 1'b0;
      r_count <= 32'd0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.Imem_Ack) begin
            r_instr <= bus.Imem_Data;
            r_valid <= 1'b1;
            r_wait  <= '0;
            r_state <= S_EXEC;
          end else if (r_wait == CNT_LAST) begin
            r_err   <= 1'b1;
            r_valid <= 1'b0;
            r_state <= S_HALT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_EXEC: begin
          // Stall and a missing PC_LdEn both mean hold.
          if (!bus.Stall && bus.PC_LdEn) begin
            r_pc    <= w_next_pc;
            r_count <= r_count + 32'd1;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Imem_Req    = (r_state == S_FETCH);
  assign bus.Imem_Addr   = r_pc;
  assign bus.Instr       = r_instr;
  assign bus.Instr_Valid = r_valid;
  assign bus.PC          = r_pc;
  assign bus.Instr_Count = r_count;
  assign bus.Fetch_Err   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic Clk;
  logic Reset;
  int   errors;
  int   checks;

  // Reference model: architectural PC and retired-instruction count.
  logic [31:0] m_pc;
  logic [31:0] m_count;

  fetch_unit_if u_if ();

  fetch_unit #(.PC_RESET(32'h0000_0000), .TIMEOUT(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (u_if.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic sel,
                                                input logic [31:0] imm);
    logic [31:0] off;
    off = sel ? imm * 32'd4 : 32'd0;
    return pc + 32'd4 + off;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    m_pc    = 32'd0;
    m_count = 32'd0;
  endtask

  // Waits (bounded) for a request, holds off the ack for 'waits' cycles, then acks.
  task automatic fetch_word(input int waits, input logic [31:0] data,
                            output logic [31:0] addr, output bit ok);
    int b;
    b  = 0;
    ok = 1'b1;
    while (!u_if.Imem_Req && b < 4) begin
      tick();
      b++;
    end
    addr = u_if.Imem_Addr;
    if (!u_if.Imem_Req) begin
      ok = 1'b0;
      return;
    end
    repeat (waits) tick();
    u_if.Imem_Ack  = 1'b1;
    u_if.Imem_Data = data;
    tick();
    u_if.Imem_Ack  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (u_if.PC !== 32'd0 || u_if.Instr_Valid !== 1'b0 || u_if.Imem_Req !== 1'b0 ||
        u_if.Instr !== 32'd0 || u_if.Instr_Count !== 32'd0 || u_if.Fetch_Err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h valid=%b req=%b instr=%h cnt=%0d err=%b, required 0/0/0/0/0/0",
               u_if.PC, u_if.Instr_Valid, u_if.Imem_Req, u_if.Instr, u_if.Instr_Count, u_if.Fetch_Err);
    end
    tick();
    checks++;
    if (u_if.Imem_Req !== 1'b1 || u_if.Imem_Addr !== 32'd0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, required 1/00000000", u_if.Imem_Req, u_if.Imem_Addr);
    end
  endtask

  task automatic test_basic();
    // Ack in the same cycle the request is seen; PC_LdEn already high.
    u_if.PC_LdEn   = 1'b1;
    u_if.PC_Sel    = 1'b0;
    u_if.Imem_Ack  = 1'b1;
    u_if.Imem_Data = 32'h8000_0000;
    tick();
    u_if.Imem_Ack  = 1'b0;
    checks++;
    if (u_if.Instr !== 32'h8000_0000 || u_if.Instr_Valid !== 1'b1 || u_if.Imem_Req !== 1'b0) begin
      errors++;
      $display("FAIL basic_exec: instr=%h valid=%b req=%b, required 80000000/1/0",
               u_if.Instr, u_if.Instr_Valid, u_if.Imem_Req);
    end
    tick();
    m_pc = model_next_pc(m_pc, 1'b0, 32'd0);
    m_count++;
    u_if.PC_LdEn = 1'b0;
    checks++;
    if (u_if.PC !== m_pc || u_if.Instr_Count !== m_count || u_if.Imem_Req !== 1'b1 ||
        u_if.Imem_Addr !== 32'd4 || u_if.Instr_Valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_retire: pc=%h cnt=%0d req=%b addr=%h valid=%b, required %h/%0d/1/00000004/0",
               u_if.PC, u_if.Instr_Count, u_if.Imem_Req, u_if.Imem_Addr, u_if.Instr_Valid, m_pc, m_count);
    end
  endtask

  task automatic test_branch();
    logic [31:0] a;
    bit ok;
    logic [31:0] sels [4];
    logic [31:0] imms [4];
    logic [31:0] want [4];
    // 4 -> 8 (seq), 8 -> 4 (imm -2), 4 -> FFFFFFFC (imm -3), FFFFFFFC -> 0 (seq wrap)
    sels = '{32'd0, 32'd1, 32'd1, 32'd0};
    imms = '{32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0};
    want = '{32'd8, 32'd4, 32'hFFFF_FFFC, 32'd0};
    for (int i = 0; i < 4; i++) begin
      fetch_word(i, 32'h1000_0000 + 32'(i), a, ok);
      checks++;
      if (!ok || a !== m_pc) begin
        errors++;
        $display("FAIL branch_req[%0d]: ok=%b addr=%h, required 1/%h", i, ok, a, m_pc);
      end
      u_if.PC_LdEn  = 1'b1;
      u_if.PC_Sel   = sels[i][0];
      u_if.PC_Immed = imms[i];
      tick();
      u_if.PC_LdEn  = 1'b0;
      u_if.PC_Sel   = 1'b0;
      m_pc = model_next_pc(m_pc, sels[i][0], imms[i]);
      m_count++;
      checks++;
      if (u_if.PC !== want[i] || u_if.PC !== m_pc || u_if.Instr_Count !== m_count) begin
        errors++;
        $display("FAIL branch_pc[%0d]: pc=%h cnt=%0d, required %h/%0d", i, u_if.PC,
                 u_if.Instr_Count, want[i], m_count);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    bit ok;
    fetch_word(2, 32'hCAFE_F00D, a, ok);
    u_if.Stall   = 1'b1;
    u_if.PC_LdEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (!ok || u_if.PC !== m_pc || u_if.Instr !== 32'hCAFE_F00D || u_if.Instr_Count !== m_count ||
          u_if.Instr_Valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: pc=%h instr=%h cnt=%0d valid=%b, required %h/cafef00d/%0d/1",
                 i, u_if.PC, u_if.Instr, u_if.Instr_Count, u_if.Instr_Valid, m_pc, m_count);
      end
    end
    u_if.Stall   = 1'b0;
    u_if.PC_LdEn = 1'b0;
    tick();
    checks++;
    if (u_if.Instr_Valid !== 1'b1 || u_if.PC !== m_pc) begin
      errors++;
      $display("FAIL ldens_low_hold: valid=%b pc=%h, required 1/%h", u_if.Instr_Valid, u_if.PC, m_pc);
    end
    u_if.PC_LdEn = 1'b1;
    tick();
    u_if.PC_LdEn = 1'b0;
    m_pc = model_next_pc(m_pc, 1'b0, 32'd0);
    m_count++;
    checks++;
    if (u_if.PC !== m_pc || u_if.Instr_Count !== m_count || u_if.Instr_Valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: pc=%h cnt=%0d valid=%b, required %h/%0d/0",
               u_if.PC, u_if.Instr_Count, u_if.Instr_Valid, m_pc, m_count);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] instr_before;
    instr_before = u_if.Instr;
    // In FETCH with the counter at zero; withhold the ack.
    repeat (15) tick();
    checks++;
    if (u_if.Fetch_Err !== 1'b0 || u_if.Imem_Req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b req=%b after 15 cycles, required 0/1",
               u_if.Fetch_Err, u_if.Imem_Req);
    end
    tick();
    checks++;
    if (u_if.Fetch_Err !== 1'b1 || u_if.Imem_Req !== 1'b0 || u_if.Instr_Valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: err=%b req=%b valid=%b after 16 cycles, required 1/0/0",
               u_if.Fetch_Err, u_if.Imem_Req, u_if.Instr_Valid);
    end
    u_if.Imem_Ack  = 1'b1;
    u_if.Imem_Data = 32'hDEAD_BEEF;
    u_if.PC_LdEn   = 1'b1;
    tick();
    tick();
    u_if.Imem_Ack  = 1'b0;
    u_if.PC_LdEn   = 1'b0;
    checks++;
    if (u_if.Instr !== instr_before || u_if.Instr_Valid !== 1'b0 || u_if.PC !== m_pc ||
        u_if.Instr_Count !== m_count || u_if.Fetch_Err !== 1'b1 || u_if.Imem_Req !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen: instr=%h valid=%b pc=%h cnt=%0d err=%b req=%b, required %h/0/%h/%0d/1/0",
               u_if.Instr, u_if.Instr_Valid, u_if.PC, u_if.Instr_Count, u_if.Fetch_Err,
               u_if.Imem_Req, instr_before, m_pc, m_count);
    end
    apply_reset();
    checks++;
    if (u_if.Fetch_Err !== 1'b0 || u_if.PC !== 32'd0) begin
      errors++;
      $display("FAIL reset_clears_err: err=%b pc=%h, required 0/00000000", u_if.Fetch_Err, u_if.PC);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] a;
    bit ok;
    // Move PC away from reset value, then sit in FETCH.
    fetch_word(0, 32'h0BAD_0001, a, ok);
    u_if.PC_LdEn = 1'b1;
    tick();
    u_if.PC_LdEn = 1'b0;
    tick();
    checks++;
    if (!ok || u_if.Imem_Req !== 1'b1 || u_if.PC !== 32'd4) begin
      errors++;
      $display("FAIL midfetch_setup: ok=%b req=%b pc=%h, required 1/1/00000004", ok, u_if.Imem_Req, u_if.PC);
    end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    m_pc    = 32'd0;
    m_count = 32'd0;
    u_if.Imem_Ack  = 1'b1;
    u_if.Imem_Data = 32'h5555_AAAA;
    checks++;
    if (u_if.Imem_Req !== 1'b0 || u_if.Instr !== 32'd0 || u_if.Instr_Valid !== 1'b0 || u_if.PC !== 32'd0) begin
      errors++;
      $display("FAIL midfetch_reset: req=%b instr=%h valid=%b pc=%h, required 0/0/0/0",
               u_if.Imem_Req, u_if.Instr, u_if.Instr_Valid, u_if.PC);
    end
    tick();
    u_if.Imem_Ack = 1'b0;
    checks++;
    if (u_if.Instr_Valid !== 1'b0 || u_if.Instr !== 32'd0 || u_if.Imem_Req !== 1'b1 ||
        u_if.Imem_Addr !== 32'd0) begin
      errors++;
      $display("FAIL stray_ack: valid=%b instr=%h req=%b addr=%h, required 0/0/1/00000000",
               u_if.Instr_Valid, u_if.Instr, u_if.Imem_Req, u_if.Imem_Addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] data;
    logic [31:0] imm;
    logic        sel;
    bit ok;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      data = $urandom;
      fetch_word(int'($urandom_range(0, 6)), data, a, ok);
      checks++;
      if (!ok || a !== m_pc || u_if.Instr !== data || u_if.Instr_Valid !== 1'b1) begin
        errors++;
        $display("FAIL rand_fetch[%0d]: ok=%b addr=%h instr=%h valid=%b, required 1/%h/%h/1",
                 i, ok, a, u_if.Instr, u_if.Instr_Valid, m_pc, data);
      end
      repeat ($urandom_range(0, 2)) begin
        u_if.Stall   = 1'b1;
        u_if.PC_LdEn = 1'($urandom);
        tick();
      end
      u_if.Stall    = 1'b0;
      sel           = 1'($urandom);
      imm           = $urandom;
      u_if.PC_Sel   = sel;
      u_if.PC_Immed = imm;
      u_if.PC_LdEn  = 1'b1;
      tick();
      u_if.PC_LdEn  = 1'b0;
      m_pc = model_next_pc(m_pc, sel, imm);
      m_count++;
      checks++;
      if (u_if.PC !== m_pc || u_if.Instr_Count !== m_count || u_if.Instr_Valid !== 1'b0 ||
          u_if.PC[1:0] !== 2'b00) begin
        errors++;
        $display("FAIL rand_retire[%0d]: pc=%h cnt=%0d valid=%b, required %h/%0d/0",
                 i, u_if.PC, u_if.Instr_Count, u_if.Instr_Valid, m_pc, m_count);
      end
    end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    Reset          = 1'b0;
    u_if.PC_Sel    = 1'b0;
    u_if.PC_LdEn   = 1'b0;
    u_if.PC_Immed  = 32'd0;
    u_if.Stall     = 1'b0;
    u_if.Imem_Ack  = 1'b0;
    u_if.Imem_Data = 32'd0;
    m_pc           = 32'd0;
    m_count        = 32'd0;

    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_timeout();
    test_reset_mid_fetch();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
